// File: rtl/ccd_sync_fifo.sv
// Single-clock FIFO staging CCD words after the async crossing, with programmable
// almost-full/empty thresholds, optional first-word-fall-through and sticky error flags.
module ccd_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic             full_reg, empty_reg, af_reg, ae_reg;
  logic             ovf_reg, ovf_next, udf_reg, udf_next;
  logic             wr_acc, rd_acc;

  // Acceptance looks only at registered FULL/EMPTY: no same-cycle bypass either way.
  always_comb begin
    wr_acc     = wr_en & ~full_reg & ~flush;
    rd_acc     = rd_en & ~empty_reg & ~flush;
    count_next = count_reg + CW'(wr_acc) - CW'(rd_acc);
    if (flush)
      count_next = '0;

    ovf_next = ovf_reg;
    if (clr_err)
      ovf_next = 1'b0;
    if (wr_en & full_reg & ~flush)
      ovf_next = 1'b1;

    udf_next = udf_reg;
    if (clr_err)
      udf_next = 1'b0;
    if (rd_en & empty_reg & ~flush)
      udf_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      af_reg     <= 1'b0;
      ae_reg     <= 1'b1;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (wr_acc)
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (rd_acc)
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      // Flags are derived from the next occupancy so they move with count.
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
      empty_reg <= (count_next == '0);
      af_reg    <= (count_next >= CW'(AF_THRESH));
      ae_reg    <= (count_next <= CW'(AE_THRESH));
      ovf_reg   <= ovf_next;
      udf_reg   <= udf_next;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr_reg] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = empty_reg ? '0 : mem[rd_ptr_reg];
      assign rd_valid = ~empty_reg;
    end else begin : g_registered
      logic [WIDTH-1:0] rd_data_reg;
      logic             rd_valid_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_acc;
          if (rd_acc)
            rd_data_reg <= mem[rd_ptr_reg];
        end
      end

      assign rd_data  = rd_data_reg;
      assign rd_valid = rd_valid_reg;
    end
  endgenerate

  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign count        = count_reg;
  assign overflow     = ovf_reg;
  assign underflow    = udf_reg;

endmodule

// File: tb/tb_ccd_sync_fifo.sv
// Scoreboard bench: a queue model predicts occupancy/flags for both read modes and
// queues expected registered-read words, which a monitor pops when rd_valid is seen.
module tb_ccd_sync_fifo;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int CW = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [W-1:0] wr_data = '0;

  logic [W-1:0]  rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1, full0, full1, empty0, empty1;
  logic          af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;
  logic [CW-1:0] count0, count1;

  ccd_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(udf0));

  ccd_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(udf1));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;
  exp_t         exp_q[$];
  logic [W-1:0] model_q[$];
  bit           m_ovf = 1'b0, m_udf = 1'b0;
  int           pat = 0;

  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Monitor for the registered-read instance.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("rd_valid_missing", 0, 1);
        void'(exp_q.pop_front());
      end
      if (rd_valid0) begin
        if (exp_q.size() == 0) begin
          chk("rd_valid_spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", int'(rd_data0), int'(e.data));
          chk("rd_latency", cyc, e.due);
        end
      end
    end
  end

  task automatic check_state();
    int n;
    n = model_q.size();
    chk("count0", int'(count0), n);
    chk("full0", int'(full0), int'(n == D));
    chk("empty0", int'(empty0), int'(n == 0));
    chk("almost_full0", int'(af0), int'(n >= 14));
    chk("almost_empty0", int'(ae0), int'(n <= 2));
    chk("overflow0", int'(ovf0), int'(m_ovf));
    chk("underflow0", int'(udf0), int'(m_udf));
    chk("count1", int'(count1), n);
    chk("full1", int'(full1), int'(n == D));
    chk("empty1", int'(empty1), int'(n == 0));
    chk("almost_full1", int'(af1), int'(n >= 14));
    chk("almost_empty1", int'(ae1), int'(n <= 2));
    chk("overflow1", int'(ovf1), int'(m_ovf));
    chk("underflow1", int'(udf1), int'(m_udf));
    chk("fwft_valid", int'(rd_valid1), int'(n != 0));
    if (n != 0)
      chk("fwft_data", int'(rd_data1), int'(model_q[0]));
  endtask

  // One clock of stimulus: predict, push expectations, clock, then compare.
  task automatic step(bit wr, logic [W-1:0] d, bit rd, bit fl, bit clr);
    bit   full_m, empty_m, wacc, racc;
    exp_t e;
    wr_en = wr; wr_data = d; rd_en = rd; flush = fl; clr_err = clr;
    full_m  = (model_q.size() == D);
    empty_m = (model_q.size() == 0);
    wacc = wr && !full_m && !fl;
    racc = rd && !empty_m && !fl;
    if (racc) begin
      e.data = model_q[0];
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
    if (!fl && wr && full_m) m_ovf = 1'b1;
    else if (clr)            m_ovf = 1'b0;
    if (!fl && rd && empty_m) m_udf = 1'b1;
    else if (clr)             m_udf = 1'b0;
    if (fl) begin
      model_q.delete();
    end else begin
      if (racc) void'(model_q.pop_front());
      if (wacc) model_q.push_back(d);
    end
    $display("cyc=%0d wr=%0b d=%02h rd=%0b flush=%0b clr=%0b -> model count=%0d",
             cyc, wr, d, rd, fl, clr, model_q.size());
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    check_state();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n, r;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rd_valid0", int'(rd_valid0), 0);
    chk("rst_rd_data0", int'(rd_data0), 0);
    chk("rst_rd_valid1", int'(rd_valid1), 0);
    check_state();
    rst_n = 1'b1;
    @(negedge clk);
    check_state();

    // Asynchronous reset with five words held
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count0", int'(count0), 0);
    chk("async_rst_empty0", int'(empty0), 1);
    chk("async_rst_ae0", int'(ae0), 1);
    chk("async_rst_full0", int'(full0), 0);
    chk("async_rst_count1", int'(count1), 0);
    chk("async_rst_valid1", int'(rd_valid1), 0);
    model_q.delete();
    exp_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state();

    // Fill and drain
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Overflow while full with a simultaneous read, then clear
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Underflow with a simultaneous write, then read back
    step(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Wrap-around holding occupancy within 3..6
    for (int i = 0; i < 3; i++) begin step(1'b1, 8'(pat), 1'b0, 1'b0, 1'b0); pat++; end
    for (int i = 0; i < 300 && pat < 43; i++) begin
      n = model_q.size();
      if (n <= 3)      r = 0;
      else if (n >= 6) r = 1;
      else             r = int'($urandom_range(0, 2));
      step(r != 1, 8'(pat), r != 0, 1'b0, 1'b0);
      if (r != 1) pat++;
      chk("wrap_range", int'(count0 >= 3 && count0 <= 6), 1);
    end
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Fall-through view, flush with traffic present
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Randomised traffic: write-heavy then read-heavy
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 70 : 30;
      step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < (100 - wp),
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
    end

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
